fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch unit and its prefetch queue.
package fetch_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: power-of-two ring buffer with occupancy counter and a flush
// that empties it in one cycle. The head entry is visible combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] LP_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W:0]   r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign full     = (r_count == LP_FULL);
    assign empty    = (r_count == '0);
    assign w_doPush = push & ~full;
    assign w_doPop  = pop & ~empty;
    assign head     = r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_doPush && !flush) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= r_count + {{PTR_W{1'b0}}, w_doPush} - {{PTR_W{1'b0}}, w_doPop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction prefetcher: one outstanding flash read at a time feeding a prefetch queue.
// Optional FETCH_PERF_EN adds a saturating stall_cnt output counting empty-queue cycles.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flash_busy,
    input  logic [DATA_W-1:0] dout_flash,
    output logic              ld_flash,
    output logic [ADDR_W-1:0] flash_addr_PC,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              ld_ir,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int ENT_W = ADDR_W + DATA_W;

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_reqAddr;

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_capture;
    logic              w_push;
    logic              w_pop;
    logic [ENT_W-1:0]  w_din;
    logic [ENT_W-1:0]  w_head;

    // Issuing from IDLE with the queue not full reserves the slot the reply will use.
    assign ld_flash      = ~rst & (r_state == ST_IDLE) & ~flash_busy & ~w_full & ~branch;
    assign w_accept      = ld_flash;
    assign flash_addr_PC = r_pc;

    assign w_capture = (r_state != ST_IDLE) & ~flash_busy;
    assign w_push    = w_capture & (r_state == ST_WAIT) & ~branch;
    assign w_pop     = ld_ir & ~w_empty & ~branch;
    assign w_din     = {dout_flash, r_reqAddr};

    assign ir_valid = ~w_empty;
    assign ir_data  = w_empty ? '0 : w_head[ENT_W-1:ADDR_W];
    assign ir_pc    = w_empty ? '0 : w_head[ADDR_W-1:0];

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (branch),
        .din   (w_din),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    // A branch that coincides with the reply retires the request outright instead of dropping it later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_reqAddr <= '0;
        end else begin
            if (branch) begin
                r_pc <= branch_addr;
            end else if (w_accept) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_accept) begin
                r_reqAddr <= r_pc;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_capture) begin
                        r_state <= ST_IDLE;
                    end else if (branch) begin
                        r_state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (w_capture) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_stallCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (w_empty && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign stall_cnt = r_stallCnt;
`endif

endmodule
